// File: rtl/sound_pkg.sv
// Shared sound package: register offsets, readback OR-masks and frame
// sequencer step decode constants used by the square, wave and noise
// channel register blocks.
package sound_pkg;

  // Register select derived from the CPU address offset from NRx0.
  typedef enum logic [2:0] {
    REG_NR0  = 3'd0,
    REG_NR1  = 3'd1,
    REG_NR2  = 3'd2,
    REG_NR3  = 3'd3,
    REG_NR4  = 3'd4,
    REG_NONE = 3'd7
  } reg_sel_e;

  localparam logic [15:0] NUM_REGS = 16'd5;

  // Readback OR-masks: write-only bits read back as 1.
  localparam logic [7:0] MASK_NR0      = 8'h80;
  localparam logic [7:0] MASK_NR1      = 8'h3F;
  localparam logic [7:0] MASK_NR2      = 8'h00;
  localparam logic [7:0] MASK_NR3      = 8'hFF;
  localparam logic [7:0] MASK_NR4      = 8'hBF;
  localparam logic [7:0] MASK_UNMAPPED = 8'hFF;

  // Frame sequencer steps. The counter parks at STEP_IDLE so the first
  // tick after enable or reset lands on step 0.
  localparam logic [2:0] STEP_IDLE    = 3'd7;
  localparam logic [2:0] STEP_SWEEP_A = 3'd2;
  localparam logic [2:0] STEP_SWEEP_B = 3'd6;
  localparam logic [2:0] STEP_VOL_ENV = 3'd7;

  // Length counter is clocked on every even step.
  function automatic logic step_is_length(input logic [2:0] step);
    return ~step[0];
  endfunction

endpackage

// File: rtl/sound_frame_seq.sv
// Frame sequencer: 3-bit step counter advanced by the 512 Hz divider tick,
// with one-cycle strobes decoded from the new step in the cycle after the
// advancing edge. GEN_SWEEP=0 ties the sweep strobe low (wave/noise use).
module sound_frame_seq
  import sound_pkg::*;
#(
  parameter bit GEN_SWEEP = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_tick,
  output logic o_clk_length_ctr,
  output logic o_clk_sweep,
  output logic o_clk_vol_env
);

  logic [2:0] r_step;
  logic       r_adv;
  logic       w_active;

  // Step counter and "advanced last edge" flag; held idle while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= STEP_IDLE;
      r_adv  <= 1'b0;
    end else if (!i_en) begin
      r_step <= STEP_IDLE;
      r_adv  <= 1'b0;
    end else begin
      r_adv <= i_tick;
      if (i_tick) r_step <= r_step + 3'd1;
    end
  end

  // Strobes are qualified by i_en so disabling drops them immediately.
  always_comb begin
    w_active         = r_adv & i_en;
    o_clk_length_ctr = w_active & step_is_length(r_step);
    o_clk_vol_env    = w_active & (r_step == STEP_VOL_ENV);
    o_clk_sweep      = 1'b0;
    if (GEN_SWEEP)
      o_clk_sweep = w_active & ((r_step == STEP_SWEEP_A) || (r_step == STEP_SWEEP_B));
  end

endmodule

// File: rtl/sound_square_regs.sv
// Square channel register block NRx0..NRx4 with trigger pulse and frame
// sequencer strobes. Optional macro SOUND_SQUARE_SWEEP_EN implements NRx0
// (frequency sweep) and the sweep strobe; without it NRx0 is unmapped.
module sound_square_regs
  import sound_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        wr,
  input  logic        apu_en,
  input  logic        div_tick,
  output logic [2:0]  sweep_time,
  output logic        sweep_decreasing,
  output logic [2:0]  num_sweep_shifts,
  output logic [1:0]  wave_duty,
  output logic [5:0]  length,
  output logic [3:0]  initial_volume,
  output logic        envelope_increasing,
  output logic [2:0]  num_envelope_sweeps,
  output logic [10:0] frequency,
  output logic        single,
  output logic        start,
  output logic        clk_length_ctr,
  output logic        clk_sweep,
  output logic        clk_vol_env
);

`ifdef SOUND_SQUARE_SWEEP_EN
  localparam bit SWEEP_EN = 1'b1;
`else
  localparam bit SWEEP_EN = 1'b0;
`endif

  logic [15:0] w_ofs;
  reg_sel_e    w_sel;
  logic        w_wr;
  logic [7:0]  r_nr1;
  logic [7:0]  r_nr2;
  logic [7:0]  r_nr3;
  logic        r_single;
  logic [2:0]  r_freq_hi;
  logic        r_start;

  assign w_ofs = a - BASE_ADDR;
  assign w_wr  = wr & apu_en;

  // Address decode: offsets 0..4 select a register, anything else is unmapped.
  always_comb begin
    w_sel = REG_NONE;
    if (w_ofs < NUM_REGS) w_sel = reg_sel_e'(w_ofs[2:0]);
  end

  // NRx1..NRx4 storage; cleared while the APU is disabled. The trigger bit
  // (din[7]) of NRx4 is not stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nr1     <= '0;
      r_nr2     <= '0;
      r_nr3     <= '0;
      r_single  <= 1'b0;
      r_freq_hi <= '0;
    end else if (!apu_en) begin
      r_nr1     <= '0;
      r_nr2     <= '0;
      r_nr3     <= '0;
      r_single  <= 1'b0;
      r_freq_hi <= '0;
    end else if (wr) begin
      case (w_sel)
        REG_NR1: r_nr1 <= din;
        REG_NR2: r_nr2 <= din;
        REG_NR3: r_nr3 <= din;
        REG_NR4: begin
          r_single  <= din[6];
          r_freq_hi <= din[2:0];
        end
        default: ;
      endcase
    end
  end

  // Trigger: registered so start lines up with the fields written by the
  // same NRx4 write; consecutive triggers give consecutive start cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_start <= 1'b0;
    else        r_start <= w_wr & (w_sel == REG_NR4) & din[7];
  end

  assign start = r_start & apu_en;

`ifdef SOUND_SQUARE_SWEEP_EN
  logic [6:0] r_nr0;

  // NRx0 sweep register, cleared while the APU is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_nr0 <= '0;
    else if (!apu_en)                    r_nr0 <= '0;
    else if (wr && (w_sel == REG_NR0))   r_nr0 <= din[6:0];
  end

  assign sweep_time       = r_nr0[6:4];
  assign sweep_decreasing = r_nr0[3];
  assign num_sweep_shifts = r_nr0[2:0];
`else
  assign sweep_time       = '0;
  assign sweep_decreasing = 1'b0;
  assign num_sweep_shifts = '0;
`endif

  assign wave_duty           = r_nr1[7:6];
  assign length              = r_nr1[5:0];
  assign initial_volume      = r_nr2[7:4];
  assign envelope_increasing = r_nr2[3];
  assign num_envelope_sweeps = r_nr2[2:0];
  assign frequency           = {r_freq_hi, r_nr3};
  assign single              = r_single;

  // CPU readback: stored bits ORed with the write-only mask of each register.
  always_comb begin
    dout = MASK_UNMAPPED;
    case (w_sel)
`ifdef SOUND_SQUARE_SWEEP_EN
      REG_NR0: dout = MASK_NR0 | {1'b0, r_nr0};
`else
      REG_NR0: dout = MASK_UNMAPPED;
`endif
      REG_NR1: dout = MASK_NR1 | r_nr1;
      REG_NR2: dout = MASK_NR2 | r_nr2;
      REG_NR3: dout = MASK_NR3 | r_nr3;
      REG_NR4: dout = MASK_NR4 | {1'b0, r_single, 6'b0};
      default: dout = MASK_UNMAPPED;
    endcase
  end

  sound_frame_seq #(
    .GEN_SWEEP(SWEEP_EN)
  ) u_frame_seq (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_en             (apu_en),
    .i_tick           (div_tick),
    .o_clk_length_ctr (clk_length_ctr),
    .o_clk_sweep      (clk_sweep),
    .o_clk_vol_env    (clk_vol_env)
  );

endmodule

// File: tb/tb_sound_square_regs.sv
// Directed bench for sound_square_regs: table of write/readback vectors
// plus hand-written sequences for trigger, frame sequencer, disable and
// reset corner cases. Expectations follow SOUND_SQUARE_SWEEP_EN if defined.
module tb_sound_square_regs;

`ifdef SOUND_SQUARE_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic        wr = 1'b0;
  logic        apu_en = 1'b1;
  logic        div_tick = 1'b0;
  logic [7:0]  dout;
  logic [2:0]  sweep_time;
  logic        sweep_decreasing;
  logic [2:0]  num_sweep_shifts;
  logic [1:0]  wave_duty;
  logic [5:0]  length;
  logic [3:0]  initial_volume;
  logic        envelope_increasing;
  logic [2:0]  num_envelope_sweeps;
  logic [10:0] frequency;
  logic        single;
  logic        start;
  logic        clk_length_ctr;
  logic        clk_sweep;
  logic        clk_vol_env;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        do_wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[12];

  sound_square_regs #(.BASE_ADDR(16'hFF10)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .a                   (a),
    .din                 (din),
    .dout                (dout),
    .wr                  (wr),
    .apu_en              (apu_en),
    .div_tick            (div_tick),
    .sweep_time          (sweep_time),
    .sweep_decreasing    (sweep_decreasing),
    .num_sweep_shifts    (num_sweep_shifts),
    .wave_duty           (wave_duty),
    .length              (length),
    .initial_volume      (initial_volume),
    .envelope_increasing (envelope_increasing),
    .num_envelope_sweeps (num_envelope_sweeps),
    .frequency           (frequency),
    .single              (single),
    .start               (start),
    .clk_length_ctr      (clk_length_ctr),
    .clk_sweep           (clk_sweep),
    .clk_vol_env         (clk_vol_env)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [15:0] addr, output logic [7:0] val);
    a = addr;
    #1;
    val = dout;
  endtask

  // Returns at the falling edge just after the write edge (start cycle).
  task automatic wr_reg(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    a   = addr;
    din = data;
    wr  = 1'b1;
    @(negedge clk);
    wr  = 1'b0;
  endtask

  // Returns at the falling edge of the strobe cycle.
  task automatic tick_once();
    @(negedge clk);
    div_tick = 1'b1;
    @(negedge clk);
    div_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    wr       = 1'b0;
    div_tick = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] m_len, m_sw, m_vol;
    int stuck;

    vecs[0]  = '{1'b1, 16'hFF12, 8'h5A, 8'h5A};
    vecs[1]  = '{1'b1, 16'hFF13, 8'hFF, 8'hFF};
    vecs[2]  = '{1'b0, 16'hFF14, 8'h00, 8'hBF};
    vecs[3]  = '{1'b0, 16'hFF15, 8'h00, 8'hFF};
    vecs[4]  = '{1'b1, 16'hFF11, 8'h81, 8'hBF};
    vecs[5]  = '{1'b1, 16'hFF10, 8'h35, SWEEP ? 8'hB5 : 8'hFF};
    vecs[6]  = '{1'b1, 16'hFF14, 8'h46, 8'hFF};
    vecs[7]  = '{1'b0, 16'hFF0F, 8'h00, 8'hFF};
    vecs[8]  = '{1'b0, 16'hFF12, 8'h00, 8'h5A};
    vecs[9]  = '{1'b1, 16'hFF12, 8'hA7, 8'hA7};
    vecs[10] = '{1'b1, 16'hFF13, 8'h12, 8'hFF};
    vecs[11] = '{1'b1, 16'hFF11, 8'h7F, 8'h7F};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_len_strobe", clk_length_ctr, 0);
    chk("rst_sweep_strobe", clk_sweep, 0);
    chk("rst_vol_strobe", clk_vol_env, 0);
    chk("rst_frequency", frequency, 0);
    chk("rst_duty", wave_duty, 0);
    chk("rst_volume", initial_volume, 0);
    chk("rst_sweep_time", sweep_time, 0);
    rd(16'hFF12, v); chk("rst_rd_ff12", v, 8'h00);
    rd(16'hFF14, v); chk("rst_rd_ff14", v, 8'hBF);
    @(negedge clk);
    rst_n = 1'b1;

    // Trigger with fields written by the same write
    wr_reg(16'hFF11, 8'h80);
    chk("nr1_no_start", start, 0);
    wr_reg(16'hFF14, 8'hC5);
    chk("trig_start", start, 1);
    chk("trig_duty", wave_duty, 2);
    chk("trig_single", single, 1);
    chk("trig_freq_hi", frequency[10:8], 5);
    @(negedge clk);
    chk("trig_start_one_cycle", start, 0);

    // Reset mid-pulse drops start and strobe at once
    do_reset();
    @(negedge clk);
    a = 16'hFF14; din = 8'h80; wr = 1'b1; div_tick = 1'b1;
    @(negedge clk);
    wr = 1'b0; div_tick = 1'b0;
    chk("midrst_start_pre", start, 1);
    chk("midrst_len_pre", clk_length_ctr, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_start", start, 0);
    chk("midrst_len", clk_length_ctr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven write/readback vectors
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_wr) wr_reg(vecs[i].addr, vecs[i].data);
      else @(negedge clk);
      rd(vecs[i].addr, v);
      chk($sformatf("vec%0d_rd_%h", i, vecs[i].addr), v, vecs[i].exp_rd);
    end
    chk("tbl_frequency", frequency, 11'h612);
    chk("tbl_volume", initial_volume, 4'hA);
    chk("tbl_env_inc", envelope_increasing, 0);
    chk("tbl_env_sweeps", num_envelope_sweeps, 7);
    chk("tbl_duty", wave_duty, 1);
    chk("tbl_length", length, 6'h3F);
    chk("tbl_single", single, 1);
    chk("tbl_sweep_time", sweep_time, SWEEP ? 3 : 0);
    chk("tbl_start", start, 0);

    // Back-to-back triggers
    @(negedge clk);
    a = 16'hFF14; din = 8'h80; wr = 1'b1;
    @(negedge clk);
    chk("b2b_first", start, 1);
    @(negedge clk);
    wr = 1'b0;
    chk("b2b_second", start, 1);
    @(negedge clk);
    chk("b2b_end", start, 0);

    // Frame sequencer: 8 ticks from reset
    do_reset();
    m_len = '0; m_sw = '0; m_vol = '0; stuck = 0;
    for (int i = 0; i < 8; i++) begin
      tick_once();
      m_len[i] = clk_length_ctr;
      m_sw[i]  = clk_sweep;
      m_vol[i] = clk_vol_env;
      @(negedge clk);
      if (clk_length_ctr || clk_sweep || clk_vol_env) stuck++;
    end
    chk("fs_length_steps", m_len, 8'h55);
    chk("fs_sweep_steps", m_sw, SWEEP ? 8'h44 : 8'h00);
    chk("fs_vol_env_steps", m_vol, 8'h80);
    chk("fs_strobe_width", stuck, 0);

    // Disable: registers cleared, writes ignored, step held
    wr_reg(16'hFF12, 8'h5A);
    rd(16'hFF12, v); chk("en_rd_ff12", v, 8'h5A);
    apu_en = 1'b0;
    @(negedge clk);
    rd(16'hFF12, v); chk("dis_cleared_ff12", v, 8'h00);
    wr_reg(16'hFF14, 8'h80);
    chk("dis_no_start", start, 0);
    wr_reg(16'hFF12, 8'h33);
    rd(16'hFF12, v); chk("dis_write_ignored", v, 8'h00);
    chk("dis_no_start_late", start, 0);
    tick_once();
    chk("dis_no_len_strobe", clk_length_ctr, 0);
    chk("dis_no_vol_strobe", clk_vol_env, 0);
    @(negedge clk);
    apu_en = 1'b1;
    tick_once();
    chk("reen_step0_len", clk_length_ctr, 1);
    chk("reen_step0_vol", clk_vol_env, 0);

    // Write and strobe in the same cycle (step 1 then step 2)
    tick_once();
    chk("step1_no_len", clk_length_ctr, 0);
    @(negedge clk);
    a = 16'hFF14; din = 8'h80; wr = 1'b1; div_tick = 1'b1;
    @(negedge clk);
    wr = 1'b0; div_tick = 1'b0;
    chk("same_cycle_start", start, 1);
    chk("same_cycle_len", clk_length_ctr, 1);
    chk("same_cycle_sweep", clk_sweep, SWEEP ? 1 : 0);

    // NRx0 write
    wr_reg(16'hFF10, 8'h7F);
    rd(16'hFF10, v); chk("nr0_rd", v, 8'hFF);
    chk("nr0_sweep_time", sweep_time, SWEEP ? 7 : 0);
    chk("nr0_sweep_dec", sweep_decreasing, SWEEP ? 1 : 0);
    chk("nr0_sweep_shifts", num_sweep_shifts, SWEEP ? 7 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sound_square_regs.md
SOUND_SQUARE_REGS -- requirements
Module: sound_square_regs

Interface
REQ-001 Parameter BASE_ADDR, default 16'hFF10, is the address of register NRx0; channel 2 instantiates it with 16'hFF15.
REQ-002 clk  in  1  CPU clock; all state SHALL be updated on the rising edge.
REQ-003 rst_n  in  1  asynchronous reset, active-low.
REQ-004 a  in  16  CPU address.
REQ-005 din  in  8  CPU write data.
REQ-006 dout  out  8  CPU read data, combinational from a.
REQ-007 wr  in  1  write strobe; one write per high cycle.
REQ-008 apu_en  in  1  master sound enable (NR52 bit 7).
REQ-009 div_tick  in  1  512 Hz one-cycle strobe from the divider.
REQ-010 sweep_time, sweep_decreasing, num_sweep_shifts  out  3/1/3  NRx0 fields [6:4]/[3]/[2:0].
REQ-011 wave_duty, length  out  2/6  NRx1 fields [7:6]/[5:0].
REQ-012 initial_volume, envelope_increasing, num_envelope_sweeps  out  4/1/3  NRx2 fields [7:4]/[3]/[2:0].
REQ-013 frequency  out  11  {NRx4[2:0], NRx3[7:0]}.
REQ-014 single  out  1  NRx4 bit 6.
REQ-015 start  out  1  one-cycle trigger pulse.
REQ-016 clk_length_ctr, clk_sweep, clk_vol_env  out  1 each  one-cycle frame-sequencer strobes.

Function
REQ-017 Registers NRx0..NRx4 SHALL decode at BASE_ADDR+0..+4 and update on the clk edge where wr=1 and apu_en=1.
REQ-018 Writes with apu_en=0 SHALL be ignored.
REQ-019 A write to NRx4 with din[7]=1 SHALL assert start for exactly the next clk cycle; din[7] is not stored.
REQ-020 All fields SHALL be stable when start is high, including fields written by that same NRx4 write.
REQ-021 Back-to-back NRx4 triggers on consecutive cycles SHALL produce start high for two consecutive cycles.
REQ-022 Readback values:
- NRx0 reads {1, stored[6:0]}.
- NRx1 reads {duty, 6'h3F}.
- NRx2 reads the full stored value.
- NRx3 reads 8'hFF.
- NRx4 reads {1, single, 6'h3F}.
- Any address outside BASE_ADDR..+4 reads 8'hFF.
REQ-023 Frame sequencer is a 3-bit step counter that SHALL advance, wrapping 7->0, on every cycle where div_tick=1 and apu_en=1.
REQ-024 The strobe cycle is the cycle after the advancing edge; strobes are decoded from the new step value:
- clk_length_ctr on steps 0,2,4,6 (256 Hz).
- clk_sweep on steps 2,6 (128 Hz).
- clk_vol_env on step 7 (64 Hz).
REQ-025 Each strobe SHALL be high for exactly one clk cycle per step.
REQ-026 A register write and a frame strobe in the same cycle SHALL both take effect.
REQ-027 While apu_en=0:
- All registers SHALL be cleared to zero.
- The step counter SHALL be held at 7, so the first div_tick after enable gives step 0.
- start and all strobes SHALL be 0.

Reset
REQ-028 On rst_n=0:
- All registers, all output fields, start and all strobes SHALL be 0.
- The step counter SHALL be 7.
REQ-029 Reset asserted mid-pulse SHALL drop start and strobes immediately.

Configuration
REQ-030 With SOUND_SQUARE_SWEEP_EN defined:
- NRx0 SHALL be implemented.
- clk_sweep SHALL be generated.
REQ-031 Without SOUND_SQUARE_SWEEP_EN:
- NRx0 writes SHALL be ignored and it SHALL read 8'hFF.
- The sweep outputs SHALL be constant 0.
- clk_sweep SHALL be tied 0.

Structure
REQ-032 A shared sound package SHALL hold:
- register offset constants.
- readback OR-masks 8'h80/8'h3F/8'h00/8'hFF/8'hBF.
- frame-step decode constants.
REQ-033 Sub-module sound_frame_seq (step counter plus strobe decode) SHALL be the single sub-module, reusable by the wave and noise channels.

Verification
REQ-034 Reset, then write FF11=8'h80 and FF14=8'hC5:
- start is high exactly one cycle.
- wave_duty=2 and single=1 during that cycle.
- frequency[10:8]=5.
REQ-035 Pulse div_tick 8 times from reset:
- clk_length_ctr fires 4 times (steps 0,2,4,6).
- clk_sweep fires 2 times (steps 2,6).
- clk_vol_env fires once (step 7).
REQ-036 Write FF12=8'h5A and FF13=8'hFF:
- FF12 reads 8'h5A.
- FF13 reads 8'hFF.
- FF14 reads 8'hBF.
- FF15 reads 8'hFF.
REQ-037 With apu_en=0, write FF14=8'h80: no start pulse and FF12 reads 8'h00; then set apu_en=1 and pulse div_tick once: clk_length_ctr fires (step 0).
REQ-038 Write FF14=8'h80 in the same cycle as a div_tick advancing to step 2: start and clk_sweep are both high in the following cycle.
REQ-039 Build without SOUND_SQUARE_SWEEP_EN and write FF10=8'h7F: FF10 reads 8'hFF, sweep_time=0, and clk_sweep never fires.
